// File: rtl/lifo_frame_reverser_if.sv
// Stream and LIFO-control signals of lifo_frame_reverser.
// master = the controller, slave = the environment (upstream, downstream, LIFO).
interface lifo_frame_reverser_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              lifo_push;
  logic [DATA_W-1:0] lifo_wdata;
  logic              lifo_pop;
  logic [DATA_W-1:0] lifo_rdata;
  logic              lifo_full;
  logic              lifo_empty;

  modport master (
    input  in_valid, in_data, in_last, out_ready, lifo_rdata, lifo_full, lifo_empty,
    output in_ready, out_valid, out_data, out_last, lifo_push, lifo_wdata, lifo_pop
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, lifo_rdata, lifo_full, lifo_empty,
    input  in_ready, out_valid, out_data, out_last, lifo_push, lifo_wdata, lifo_pop
  );
endinterface

// File: rtl/lifo_frame_reverser.sv
// Pushes an input frame into an external LIFO, then pops it dry and
// replays the words last-in-first-out on the output stream.
module lifo_frame_reverser #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lifo_frame_reverser_if.master  bus,
  output logic                   overflow,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_DISCARD,
    S_POP,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_flag_q, last_flag_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              overflow_q, overflow_d;
  logic              err_q, err_d;
  logic              in_ready, accept, lifo_push, lifo_pop;

  // Full flag is informational only; the occupancy counter drives control.
  logic unused_full;
  assign unused_full = bus.lifo_full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      count_q     <= '0;
      last_flag_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_flag_q <= last_flag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_flag_d = last_flag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = 1'b0;
    err_d       = err_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    lifo_push   = 1'b0;
    lifo_pop    = 1'b0;

    unique case (state_q)
      S_FILL: begin
        in_ready = (count_q < DEPTH_C);
        accept   = bus.in_valid && in_ready;
        if (accept) begin
          lifo_push = 1'b1;
          count_d   = count_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = S_POP;
          end else if (count_q == DEPTH_C - CNT_W'(1)) begin
            overflow_d = 1'b1;
            state_d    = S_DISCARD;
          end
        end
      end

      // Stack is full: swallow the rest of the frame until its last beat.
      S_DISCARD: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (accept && bus.in_last) state_d = S_POP;
      end

      S_POP: begin
        lifo_pop    = 1'b1;
        last_flag_d = (count_q == CNT_W'(1));
        if (count_q != '0) count_d = count_q - CNT_W'(1);
        if (bus.lifo_empty && count_q != '0) err_d = 1'b1;
        state_d = S_WAIT;
      end

      // Pop data arrives one cycle after the strobe.
      S_WAIT: begin
        out_data_d  = bus.lifo_rdata;
        out_last_d  = last_flag_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (count_q != '0) ? S_POP : S_FILL;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.lifo_push  = lifo_push;
  assign bus.lifo_wdata = bus.in_data;
  assign bus.lifo_pop   = lifo_pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign overflow       = overflow_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Scoreboard bench for lifo_frame_reverser with a behavioural LIFO attached;
// directed frames queue their hand-computed reversed words, a monitor compares.
module tb_lifo_frame_reverser;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overflow, err;

  always #5 clk = ~clk;

  lifo_frame_reverser_if #(.DATA_W(DATA_W)) bus ();

  lifo_frame_reverser #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .overflow (overflow),
    .err      (err)
  );

  // Behavioural LIFO, reset together with the controller.
  logic [DATA_W-1:0] mem [DEPTH];
  int   sp;
  logic force_empty = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp             <= 0;
      bus.lifo_rdata <= '0;
    end else if (bus.lifo_pop && sp > 0) begin
      bus.lifo_rdata <= mem[sp-1];
      sp             <= sp - 1;
    end else if (bus.lifo_push && sp < DEPTH) begin
      mem[sp] <= bus.lifo_wdata;
      sp      <= sp + 1;
    end
  end

  assign bus.lifo_full  = (sp == DEPTH);
  assign bus.lifo_empty = force_empty || (sp == 0);

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, hs_cyc = 0, first_cyc = 0;
  bit   first_seen = 1'b0;
  int   push_cnt = 0, pop_cnt = 0, collide = 0, ovf_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.lifo_push) push_cnt++;
      if (bus.lifo_pop) pop_cnt++;
      if (bus.lifo_push && bus.lifo_pop) collide++;
      if (overflow) ovf_cnt++;
      if (bus.out_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_data), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.data));
          check("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        hs_cyc = cyc;
        done   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("in_handshake_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait until every queued word has been seen; counts in_ready highs meanwhile.
  task automatic drain(output int rdy_hi);
    bit done = 1'b0;
    rdy_hi = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
      else if (bus.in_ready) rdy_hi++;
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.out_valid) done = 1'b1;
    end
    if (!done) check("out_valid_timeout", 0, 1);
  endtask

  task automatic clear_stats();
    first_seen = 1'b0;
    push_cnt   = 0;
    pop_cnt    = 0;
    ovf_cnt    = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy_hi, pc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_err", 32'(err), 0);
    check("rst_lifo_pop", 32'(bus.lifo_pop), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // 3-word frame, free-running output
    clear_stats();
    push_exp(4'h3, 1'b0); push_exp(4'h2, 1'b0); push_exp(4'h1, 1'b1);
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b1);
    drain(rdy_hi);
    check("t1_latency", 32'(first_cyc - hs_cyc), 3);
    check("t1_overflow", 32'(ovf_cnt), 0);
    check("t1_pushes", 32'(push_cnt), 3);
    check("t1_pops", 32'(pop_cnt), 3);

    // Exactly DEPTH words: no overflow, straight to drain
    clear_stats();
    for (int i = 7; i >= 0; i--) push_exp(DATA_W'(i), i == 0);
    for (int i = 0; i < 8; i++) send(DATA_W'(i), i == 7);
    drain(rdy_hi);
    check("t2_latency", 32'(first_cyc - hs_cyc), 3);
    check("t2_overflow", 32'(ovf_cnt), 0);
    check("t2_in_ready_in_drain", 32'(rdy_hi), 0);

    // 10-word frame: overflow after the 8th beat, extra beats dropped
    clear_stats();
    for (int i = 7; i >= 0; i--) push_exp(DATA_W'(i), i == 0);
    for (int i = 0; i < 10; i++) begin
      send(DATA_W'(i), i == 9);
      if (i == 7) check("t3_overflow_pulse", 32'(overflow), 1);
    end
    drain(rdy_hi);
    check("t3_overflow_count", 32'(ovf_cnt), 1);
    check("t3_pushes", 32'(push_cnt), 8);
    check("t3_pops", 32'(pop_cnt), 8);

    // Back-pressure: first output held for 5 cycles
    clear_stats();
    bus.out_ready = 1'b0;
    push_exp(4'h3, 1'b0); push_exp(4'h2, 1'b0); push_exp(4'h1, 1'b1);
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b1);
    wait_out_valid();
    pc = pop_cnt;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", 32'(bus.out_valid), 1);
      check("t4_hold_data", 32'(bus.out_data), 3);
      check("t4_hold_last", 32'(bus.out_last), 0);
      @(negedge clk);
    end
    check("t4_no_extra_pop", 32'(pop_cnt), 32'(pc));
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain(rdy_hi);

    // Reset while holding the first output of a 4-word frame
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(DATA_W'(i), i == 4);
    wait_out_valid();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(bus.out_valid), 0);
    check("t5_rst_out_data", 32'(bus.out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t5_in_ready", 32'(bus.in_ready), 1);
    check("t5_err", 32'(err), 0);
    // A 1-word frame right after reset proves the counter restarted at zero
    push_exp(4'h5, 1'b1);
    @(posedge clk); #1;
    send(4'h5, 1'b1);
    drain(rdy_hi);
    repeat (8) @(negedge clk);
    check("t5_no_leftover", 32'(exp_q.size()), 0);

    // LIFO reports empty during the first pop of a 2-word frame
    check("t6_err_before", 32'(err), 0);
    push_exp(4'hB, 1'b0); push_exp(4'hA, 1'b1);
    @(posedge clk); #1;
    send(4'hA, 1'b0); send(4'hB, 1'b1);
    force_empty = 1'b1;
    @(posedge clk); #1 force_empty = 1'b0;
    check("t6_err_set", 32'(err), 1);
    drain(rdy_hi);
    repeat (5) @(posedge clk);
    #1 check("t6_err_sticky", 32'(err), 1);
    rst_n = 1'b0;
    #1 check("t6_err_cleared", 32'(err), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    check("push_pop_together", 32'(collide), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
